// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state type, frame constants and command-word builder for the serial ADC controller
package adc_ctrl_pkg;
  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS = 12;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;
  function automatic logic [FRAME_BITS-1:0] cmd_word(input logic [2:0] ch);
    return {1'b1, ch, {(FRAME_BITS-4){1'b0}}};
  endfunction
endpackage

// File: rtl/adc_serial_ctrl_if.sv
// adc_serial_ctrl_if: CPU request/result handshake plus ADC pin bundle
interface adc_serial_ctrl_if;
  import adc_ctrl_pkg::*;
  logic START;
  logic [2:0] CH;
  logic BUSY;
  logic DONE;
  logic [DATA_BITS-1:0] DATA;
  logic ADC_CS_N;
  logic ADC_SCLK;
  logic ADC_DIN;
  logic ADC_DOUT;
  modport slave(input START, CH, ADC_DOUT, output BUSY, DONE, DATA, ADC_CS_N, ADC_SCLK, ADC_DIN);
  modport master(output START, CH, ADC_DOUT, input BUSY, DONE, DATA, ADC_CS_N, ADC_SCLK, ADC_DIN);
endinterface

// File: rtl/adc_sclk_prescaler.sv
// adc_sclk_prescaler: half-period tick generator for the ADC serial clock
module adc_sclk_prescaler #(
  parameter int HALF_DIV = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic ENA,
  output logic TICK
);
  localparam int CW = $clog2(HALF_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    TICK = ENA && (cnt_q == CW'(HALF_DIV - 1));
    cnt_d = CLR ? '0 : !ENA ? cnt_q : TICK ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/adc_serial_ctrl.sv
// adc_serial_ctrl: runs one 16-bit SPI conversion frame on the serial ADC per accepted START
module adc_serial_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int HALF_DIV = 25
) (
  input logic CLK,
  input logic RST,
  adc_serial_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d, cmd;
  logic [4:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic busy_q, busy_d, done_q, done_d, cs_n_q, cs_n_d, sclk_q, sclk_d, din_q, din_d;
  logic tick;
  adc_sclk_prescaler #(.HALF_DIV(HALF_DIV)) u_presc (
    .CLK(CLK),
    .RST(RST),
    .CLR(state_q == IDLE),
    .ENA(state_q != IDLE),
    .TICK(tick)
  );
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    bit_d = bit_q;
    data_d = data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cs_n_d = cs_n_q;
    sclk_d = sclk_q;
    din_d = din_q;
    cmd = cmd_word(bus.CH);
    case (state_q)
      IDLE: if (bus.START) begin
        state_d = SETUP;
        tx_d = {cmd[FRAME_BITS-2:0], 1'b0};
        din_d = cmd[FRAME_BITS-1];
        cs_n_d = 1'b0;
        busy_d = 1'b1;
      end
      SETUP: begin
        bit_d = '0;
        state_d = tick ? SHIFT : SETUP;
      end
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        // ADC drives on falling SCLK, so sample on our rising half and update DIN on the falling one
        if (!sclk_q) rx_d = {rx_q[FRAME_BITS-2:0], bus.ADC_DOUT};
        else begin
          bit_d = bit_q + 1'b1;
          din_d = tx_q[FRAME_BITS-1];
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == 5'(FRAME_BITS - 1)) begin
            state_d = GAP;
            cs_n_d = 1'b1;
            din_d = 1'b0;
          end
        end
      end
      GAP: if (tick) begin
        state_d = IDLE;
        data_d = rx_q[FRAME_BITS-1 -: DATA_BITS];
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tx_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      din_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      din_q <= din_d;
    end
  end
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.DATA = data_q;
  assign bus.ADC_CS_N = cs_n_q;
  assign bus.ADC_SCLK = sclk_q;
  assign bus.ADC_DIN = din_q;
endmodule

// File: tb/tb_adc_serial_ctrl.sv
// tb_adc_serial_ctrl: three controller instances (HALF_DIV 2, 3, 25) with ADC models and a result scoreboard
module tb_adc_serial_ctrl;
  typedef struct {
    int id;
    logic [11:0] data;
    logic [15:0] cmd;
    int done_cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] ch = '0;
  int sel = 0;
  logic [15:0] pat = '0;
  logic duty_en = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic cs_n_a[3], sclk_a[3], din_a[3], busy_a[3], done_a[3];
  logic [11:0] data_a[3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int hd(input int id);
    return id == 0 ? 2 : id == 1 ? 3 : 25;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int HD = k == 0 ? 2 : k == 1 ? 3 : 25;
    adc_serial_ctrl_if u_if();
    adc_serial_ctrl #(.HALF_DIV(HD)) u_dut (.CLK(clk), .RST(rst), .bus(u_if.slave));
    assign u_if.START = start && (sel == k);
    assign u_if.CH = ch;
    assign cs_n_a[k] = u_if.ADC_CS_N;
    assign sclk_a[k] = u_if.ADC_SCLK;
    assign din_a[k] = u_if.ADC_DIN;
    assign busy_a[k] = u_if.BUSY;
    assign done_a[k] = u_if.DONE;
    assign data_a[k] = u_if.DATA;
    int rises = 0, hi_cs = 0, hi_s = 0, lo_s = 0;
    logic [15:0] din_w = '0;
    logic cs_p = 1'b1, sclk_p = 1'b0;
    exp_t e;
    // ADC model: shifts its pattern out MSB first, changing DOUT after each SCLK rise
    always @(negedge clk) begin
      if (!u_if.ADC_CS_N && cs_p) begin
        chk($sformatf("cs_gap%0d", k), 32'(hi_cs >= HD), 1);
        rises = 0;
        din_w = '0;
        lo_s = 0;
      end
      hi_cs = u_if.ADC_CS_N ? hi_cs + 1 : 0;
      if (u_if.ADC_SCLK && !sclk_p) begin
        if (duty_en && rises > 0) chk($sformatf("sclk_low%0d", k), lo_s, HD);
        din_w = {din_w[14:0], u_if.ADC_DIN};
        rises++;
      end
      if (duty_en && !u_if.ADC_SCLK && sclk_p) chk($sformatf("sclk_high%0d", k), hi_s, HD);
      hi_s = u_if.ADC_SCLK ? hi_s + 1 : 0;
      lo_s = u_if.ADC_SCLK ? 0 : lo_s + 1;
      cs_p = u_if.ADC_CS_N;
      sclk_p = u_if.ADC_SCLK;
      u_if.ADC_DOUT = (!u_if.ADC_CS_N && rises < 16) ? pat[15-rises] : 1'b0;
      if (u_if.DONE) begin
        chk($sformatf("done_expected%0d", k), 32'(sb.size() != 0 && sb[0].id == k), 1);
        if (sb.size() != 0 && sb[0].id == k) begin
          e = sb.pop_front();
          chk($sformatf("data%0d", k), u_if.DATA, e.data);
          chk($sformatf("din_word%0d", k), din_w, e.cmd);
          chk($sformatf("sclk_rises%0d", k), rises, 16);
          chk($sformatf("done_cycle%0d", k), cyc, e.done_cyc);
        end
      end
    end
  end
  task automatic push(input int id, input logic [2:0] c, input logic [15:0] p, input int dc);
    exp_t x;
    x.id = id;
    x.data = p[15:4];
    x.cmd = {1'b1, c, 12'h000};
    x.done_cyc = dc;
    sb.push_back(x);
  endtask
  task automatic go(input int id, input logic [2:0] c, input logic [15:0] p, input bit expect_done);
    sel = id;
    ch = c;
    pat = p;
    start = 1'b1;
    if (expect_done) push(id, c, p, cyc + 34 * hd(id) + 1);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic chk_outs(input int k, input logic [11:0] d);
    chk($sformatf("cs_n%0d", k), cs_n_a[k], 1);
    chk($sformatf("sclk%0d", k), sclk_a[k], 0);
    chk($sformatf("din%0d", k), din_a[k], 0);
    chk($sformatf("busy%0d", k), busy_a[k], 0);
    chk($sformatf("done%0d", k), done_a[k], 0);
    chk($sformatf("data_idle%0d", k), data_a[k], d);
  endtask
  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_outs(k, 12'h000);
    end
    rst = 1'b0;
    @(negedge clk);
    go(0, 3'd5, 16'hA5C6, 1'b1);
    repeat (10) @(negedge clk);
    ch = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_frame", busy_a[0], 1);
    wait_empty(200);
    repeat (10) @(negedge clk);
    chk("data_hold", data_a[0], 12'hA5C);
    rst = 1'b1;
    start = 1'b1;
    ch = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk_outs(0, 12'h000);
    @(negedge clk);
    chk("rst_beats_start", busy_a[0], 0);
    go(0, 3'd3, 16'h1234, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outs(0, 12'h000);
    repeat (80) @(negedge clk);
    chk("abort_data", data_a[0], 12'h000);
    chk("abort_busy", busy_a[0], 0);
    go(0, 3'd3, 16'h1234, 1'b1);
    wait_empty(200);
    sel = 1;
    ch = 3'd6;
    pat = 16'h7E1F;
    start = 1'b1;
    for (int i = 1; i <= 3; i++) push(1, 3'd6, 16'h7E1F, cyc + 103 * i);
    repeat (308) @(negedge clk);
    start = 1'b0;
    wait_empty(400);
    repeat (10) @(negedge clk);
    duty_en = 1'b1;
    go(2, 3'd0, 16'h3C9A, 1'b1);
    wait_empty(1000);
    duty_en = 1'b0;
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_serial_ctrl.md
Name: adc_serial_ctrl

Overview:
- Sequences one 16-bit SPI conversion frame to the board's 8-channel, 12-bit serial ADC on each START request.
- Derives ADC_SCLK from CLK using an internal half-period prescaler tick; the prescaler runs only while a frame is active.
- Returns the 12-bit result with a one-cycle DONE strobe.
- Sits between the CPU's I/O register block and the ADC pins.

Parameters:
- HALF_DIV, 25, CLK cycles per ADC_SCLK half-period (50 MHz / (2 x 1 MHz)); legal values >= 2.
- FRAME_BITS, 16, SCLK periods per frame.
- DATA_BITS, 12, result width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- START  in  1  conversion request; sampled only in IDLE.
- CH  in  3  channel select; latched when START is accepted.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle strobe; DATA is valid from this cycle onward.
- DATA  out  DATA_BITS  last conversion result; held until the next DONE.
- ADC_CS_N  out  1  chip select, active-low.
- ADC_SCLK  out  1  serial clock; idles low.
- ADC_DIN  out  1  command bit to the ADC.
- ADC_DOUT  in  1  result bit from the ADC.

Behaviour:
- All interface timing is synchronous to CLK; all outputs are registered.
- Reset values: BUSY=0, DONE=0, DATA=0, ADC_CS_N=1, ADC_SCLK=0, ADC_DIN=0; state=IDLE; prescaler count=0.
- Prescaler tick:
  - tick=1 when count==HALF_DIV-1 and the prescaler is enabled.
  - Count wraps to 0 on tick.
  - Count is cleared on entering SETUP and held at 0 in IDLE.
- Command word, shifted MSB first: {1'b1, CH[2:0], 12'b0}.
- States:
  - IDLE:
    - START=1 -> SETUP.
    - Latch CH; ADC_CS_N<=0; ADC_DIN<=bit15; BUSY<=1.
  - SETUP:
    - Wait one tick (CS setup time), then -> SHIFT.
    - Bit counter = 0.
  - SHIFT:
    - On each tick, toggle ADC_SCLK.
    - Rising tick (SCLK 0->1): shift ADC_DOUT into the receive shift register.
    - Falling tick (SCLK 1->0): increment the bit counter and drive the next command bit on ADC_DIN.
    - After the 16th falling tick: -> GAP; ADC_CS_N<=1; ADC_DIN<=0.
  - GAP:
    - Wait one tick (CS high time), then -> IDLE.
    - In the same cycle: DATA<=first 12 received bits (MSB first); DONE<=1; BUSY<=0.
    - The last 4 received bits are discarded.
- Latency: counting the START-sampling cycle as 0, DONE is high in cycle 34*HALF_DIV+1.
  - ADC_CS_N is low in cycles 1 .. 33*HALF_DIV.
- Boundary conditions:
  - START while BUSY: ignored, with no effect on the frame or CH.
  - START in the DONE cycle: accepted (state is IDLE), giving back-to-back frames; CS_N is high for at least HALF_DIV cycles between frames.
  - CH changing mid-frame: no effect.
  - RST mid-frame: on the next edge every output and state returns to its reset value; ADC_CS_N rises immediately; no DONE is produced.
  - Simultaneous RST and START: RST wins.
- Width rule: prescaler count width = ceiling-log2(HALF_DIV), computed with the team's existing ceiling-log2 function; the bit counter is 5 bits.

Decomposition:
- Package adc_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, GAP);
  - FRAME_BITS and DATA_BITS constants;
  - the command-word build function cmd_word(ch).
- Sub-module adc_sclk_prescaler(CLK, RST, CLR, ENA, TICK) is parameterised by HALF_DIV and has synchronous active-high RST and CLR.
- The FSM, shift registers and bit counter are in adc_serial_ctrl.

Test Plan:
- Reset check (HALF_DIV=2): assert RST for 3 cycles -> CS_N=1, SCLK=0, DIN=0, BUSY=0, DONE=0, DATA=0 in every cycle.
- Single conversion (HALF_DIV=2): START with CH=5 at cycle 0; ADC model returns 0xA5C followed by 4 junk bits ->
  - DIN sequence is 1,1,0,1 followed by twelve 0s;
  - exactly 16 SCLK rising edges occur;
  - DONE is high only in cycle 69;
  - DATA=0xA5C.
- Busy rejection: a second START with CH=2 mid-frame -> a single frame whose DIN encodes CH=5; only one DONE pulse.
- Back-to-back: START held high continuously with HALF_DIV=3 ->
  - consecutive DONE strobes exactly 103 cycles apart;
  - CS_N is high for >= 3 cycles between frames.
- Reset mid-frame: RST at cycle 20 of a frame ->
  - CS_N=1 and SCLK=0 at the next edge;
  - no DONE;
  - DATA stays 0;
  - a new START afterwards completes normally.
- Timing at default HALF_DIV=25: ADC_SCLK period = 50 CLK cycles with 50% duty; DONE is high in cycle 851.
